bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//  Loadable 5-digit BCD countdown timer (xx.xxx s, 1 ms resolution).
//  Consumes the fishTime/reelTime values from the difficulty selector.
//  reelTime is loaded zero-padded as {8'h00, reelTime}.
//  The game controller instantiates one timer per use (reel, catch/wait).
//  Gating, pausing and timeout reporting are handled here; the controller only sees timeout.
// PARAMETERS
//  TICKS_PER_MS  50000  CLK cycles per 1 ms decrement (50 MHz board clock)
//  PRESC_W       16     prescaler width; must satisfy 2**PRESC_W >= TICKS_PER_MS
// PORTS
//  CLK        in   1   system clock
//  RST        in   1   synchronous, active-high reset
//  loadTime   in   1   pulse: load startValue and arm the timer
//  startValue in   20  BCD start time {tens,ones,tenths,hundths,thouths}
//  countEn    in   1   level: count while high, freeze while low (e.g. LED in winZone)
//  timeLeft   out  20  current BCD remaining time (registered)
//  running    out  1   high in RUN state
//  timeout    out  1   one-cycle pulse when remaining time reaches 00.000
// BEHAVIOUR
//  Reset (RST=1 at a CLK edge):
//   - state=IDLE, timeLeft=20'h00000, prescaler=0
//   - running=0, timeout=0
//   - Reset overrides every other input, including mid-count.
//  States:
//   - IDLE: holds timeLeft; waits for loadTime.
//   - RUN: counting (gated by countEn).
//   - DONE: timeLeft=0; waits for loadTime.
//  Load (any state, loadTime=1):
//   - timeLeft <= startValue with each digit >9 clamped to 9; prescaler <= 0.
//   - Next state RUN if the clamped value is nonzero, else DONE.
//   - Load to zero: timeout pulses in the cycle after the load edge.
//   - Load has priority over a same-cycle decrement or timeout.
//   - Reloading in RUN restarts cleanly; no pulse from the old count.
//  RUN, countEn=1:
//   - prescaler increments each cycle.
//   - When prescaler==TICKS_PER_MS-1: prescaler<=0 and timeLeft decrements by 1 ms.
//   - Borrow chain: a digit at 0 becomes 9 and borrows from the next digit.
//   - Example: 01.000 -> 00.999; 10.000 -> 09.999.
//  RUN, countEn=0:
//   - prescaler and timeLeft hold (pause, not reset).
//   - Resuming continues the partial ms.
//  Terminal: the decrement that yields 00.000 moves the state to DONE.
//   - timeout=1 for exactly the one cycle registered with that transition
//     (same edge timeLeft becomes 0).
//   - No underflow: DONE never decrements.
//  running=1 iff state==RUN; it drops on the same edge timeout rises.
//  loadTime held high: reloads every cycle, so no counting occurs.
//  Latency:
//   - Load -> timeLeft valid: 1 cycle.
//   - Load of N ms -> timeout: N*TICKS_PER_MS cycles of countEn=1 after the load edge.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING (bench uses TICKS_PER_MS=4)
//  1 Reset mid-count: load 00.050, count 20 cycles, RST=1
//    -> timeLeft=00000, running=0, timeout=0 next cycle.
//  2 Borrow chain: load 20'h10000, countEn=1, 4 cycles
//    -> timeLeft=20'h09999; after 4 more cycles -> 20'h09998.
//  3 Terminal: load 00.003, countEn=1
//    -> timeout high for exactly 1 cycle 12 cycles after load; timeLeft=0.
//    -> Stays 0 and timeout stays low for 100 further cycles.
//  4 Pause: load 00.002, countEn=1 for 2 cycles, 0 for 10, then 1
//    -> timeout occurs 8 enabled cycles after load (pause adds 10 cycles).
//  5 Load priority / zero load: load 00.001, then assert loadTime with 05.000 on the timeout cycle
//    -> no timeout pulse, timeLeft=05000, running=1.
//    Separately: load 00.000 -> timeout pulse the next cycle.
//  6 Clamp: load 20'hFA3C1 -> timeLeft=20'h99391 after 1 cycle.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: loadable 5-digit BCD countdown (xx.xxx s, 1 ms steps)
// with pause gating and a one-cycle timeout pulse on reaching 00.000.
module bcd_countdown_timer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int PRESC_W      = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        loadTime,
    input  logic [19:0] startValue,
    input  logic        countEn,
    output logic [19:0] timeLeft,
    output logic        running,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, stateNext;
    logic [PRESC_W-1:0] presc, prescNext;
    logic [19:0]        timeNext, clamped, decremented;
    logic               timeoutNext, tick, borrow;

    for (genvar g = 0; g < 5; g++) begin : g_clamp
        assign clamped[4*g +: 4] = (startValue[4*g +: 4] > 4'd9) ? 4'd9 : startValue[4*g +: 4];
    end

    // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward.
    always_comb begin
        decremented = timeLeft;
        borrow      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (borrow) begin
                if (timeLeft[4*i +: 4] == 4'd0) begin
                    decremented[4*i +: 4] = 4'd9;
                end else begin
                    decremented[4*i +: 4] = timeLeft[4*i +: 4] - 4'd1;
                    borrow                = 1'b0;
                end
            end
        end
    end

    assign tick    = (state == RUN) && countEn && (presc == PRESC_W'(TICKS_PER_MS - 1));
    assign running = (state == RUN);

    always_comb begin
        stateNext   = state;
        timeNext    = timeLeft;
        prescNext   = presc;
        timeoutNext = 1'b0;
        if (loadTime) begin
            timeNext    = clamped;
            prescNext   = '0;
            stateNext   = (clamped != 20'h0) ? RUN : DONE;
            timeoutNext = (clamped == 20'h0);
        end else if (state == RUN && countEn) begin
            prescNext = tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                timeNext = decremented;
                if (decremented == 20'h0) begin
                    stateNext   = DONE;
                    timeoutNext = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            timeLeft <= 20'h0;
            presc    <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= stateNext;
            timeLeft <= timeNext;
            presc    <= prescNext;
            timeout  <= timeoutNext;
        end
    end
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: vector table, directed corner sequences and a
// randomized run against an integer-millisecond reference model.
module tb_bcd_countdown_timer;
    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        RST, loadTime, countEn;
    logic [19:0] startValue, timeLeft;
    logic        running, timeout;
    int          nAssert = 0, nFail = 0;
    int          mMs = 0, mSub = 0;
    logic        mRun = 1'b0, mTo = 1'b0;

    always #5 CLK = ~CLK;

    bcd_countdown_timer #(.TICKS_PER_MS(T), .PRESC_W(16)) dut (
        .CLK(CLK), .RST(RST), .loadTime(loadTime), .startValue(startValue),
        .countEn(countEn), .timeLeft(timeLeft), .running(running), .timeout(timeout)
    );

    typedef struct {
        logic        rst, load, en;
        logic [19:0] sv, expT;
        logic        expR, expTo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic load, logic en, logic [19:0] sv,
                                logic [19:0] expT, logic expR, logic expTo);
        vec_t v;
        v.rst = rst; v.load = load; v.en = en; v.sv = sv;
        v.expT = expT; v.expR = expR; v.expTo = expTo;
        return v;
    endfunction

    function automatic int bcdToInt(logic [19:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < 5; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [19:0] intToBcd(int n);
        logic [19:0] r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n /= 10;
        end
        return r;
    endfunction

    task automatic check(string name, logic [19:0] act, logic [19:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(string name, logic [19:0] t, logic r, logic to);
        check({name, ".timeLeft"}, timeLeft, t);
        check({name, ".running"}, 20'(running), 20'(r));
        check({name, ".timeout"}, 20'(timeout), 20'(to));
    endtask

    // Reference: remaining time as integer ms plus enabled cycles into the current ms.
    task automatic modelStep();
        if (RST) begin
            mMs = 0; mSub = 0; mRun = 1'b0; mTo = 1'b0;
        end else if (loadTime) begin
            mMs = bcdToInt(startValue); mSub = 0;
            mRun = (mMs != 0); mTo = (mMs == 0);
        end else begin
            mTo = 1'b0;
            if (mRun && countEn) begin
                mSub++;
                if (mSub == T) begin
                    mSub = 0;
                    mMs--;
                    if (mMs == 0) begin
                        mRun = 1'b0;
                        mTo  = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    initial begin
        int n;
        int bad;
        RST = 1'b1; loadTime = 1'b0; countEn = 1'b0; startValue = '0;

        vecs.push_back(mk(1, 0, 0, 20'h0,     20'h00000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 20'hFA3C1, 20'h99391, 1, 0));
        vecs.push_back(mk(0, 0, 0, 20'h0,     20'h99391, 1, 0));
        vecs.push_back(mk(0, 1, 1, 20'h10000, 20'h10000, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 20'h0, 20'h10000, 1, 0));
        vecs.push_back(mk(0, 0, 1, 20'h0,     20'h09999, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 20'h0, 20'h09999, 1, 0));
        vecs.push_back(mk(0, 0, 1, 20'h0,     20'h09998, 1, 0));
        vecs.push_back(mk(0, 1, 0, 20'h00000, 20'h00000, 0, 1));
        vecs.push_back(mk(0, 0, 1, 20'h0,     20'h00000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 20'h00001, 20'h00001, 1, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 20'h0, 20'h00001, 1, 0));
        vecs.push_back(mk(1, 1, 1, 20'h12345, 20'h00000, 0, 0));

        foreach (vecs[i]) begin
            RST = vecs[i].rst; loadTime = vecs[i].load;
            countEn = vecs[i].en; startValue = vecs[i].sv;
            cyc();
            checkAll($sformatf("vec%0d", i), vecs[i].expT, vecs[i].expR, vecs[i].expTo);
        end
        RST = 1'b0; loadTime = 1'b0;

        loadTime = 1'b1; startValue = 20'h00050; countEn = 1'b1; cyc();
        loadTime = 1'b0;
        repeat (20) cyc();
        checkAll("midCount", 20'h00045, 1, 0);
        RST = 1'b1; cyc(); RST = 1'b0;
        checkAll("rstMid", 20'h00000, 0, 0);

        loadTime = 1'b1; startValue = 20'h00003; cyc();
        loadTime = 1'b0; n = 0;
        while (!timeout && n < 50) begin cyc(); n++; end
        check("termLatency", 20'(n), 20'd12);
        checkAll("term", 20'h00000, 0, 1);
        bad = 0;
        repeat (100) begin
            cyc();
            if (timeout || running || timeLeft != 20'h0) bad++;
        end
        check("termHold", 20'(bad), 20'd0);

        loadTime = 1'b1; startValue = 20'h00002; countEn = 1'b1; cyc();
        loadTime = 1'b0; n = 0;
        repeat (2) begin cyc(); n++; end
        countEn = 1'b0;
        repeat (10) begin cyc(); n++; end
        checkAll("paused", 20'h00002, 1, 0);
        countEn = 1'b1;
        while (!timeout && n < 60) begin cyc(); n++; end
        check("pauseLatency", 20'(n), 20'd18);

        loadTime = 1'b1; startValue = 20'h00001; cyc();
        loadTime = 1'b0;
        repeat (3) cyc();
        loadTime = 1'b1; startValue = 20'h05000; cyc();
        checkAll("loadPrio", 20'h05000, 1, 0);
        loadTime = 1'b0; cyc();
        checkAll("loadPrioAfter", 20'h05000, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            RST        = ($urandom % 200) == 0;
            loadTime   = ($urandom % 16) == 0;
            startValue = ($urandom % 4 == 0) ? 20'($urandom) : intToBcd(int'($urandom % 12));
            countEn    = ($urandom % 4) != 0;
            cyc();
            checkAll($sformatf("rand%0d", i), intToBcd(mMs), mRun, mTo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
